// File: rtl/scdaq_capture_pkg.sv
// rtl/scdaq_capture_pkg.sv - shared FSM state encoding for the SCDAQ acquisition memory
package scdaq_capture_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PRE      = 3'd1,
      ST_WAIT_TRG = 3'd2,
      ST_POST     = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

endpackage

// File: rtl/scdaq_capture_if.sv
// rtl/scdaq_capture_if.sv - sample stream, control, status and host read bundle
interface scdaq_capture_if #(
   parameter int PRECISION  = 8,
   parameter int DEPTH_LOG2 = 10
);
   logic [PRECISION-1:0]  DAQ_D;
   logic                  DAQ_Trg;
   logic                  CTL_Arm;
   logic                  CTL_Abort;
   logic [DEPTH_LOG2-1:0] CFG_PRE;
   logic                  STS_Busy;
   logic                  STS_Triggered;
   logic                  STS_Done;
   logic                  RD_Req;
   logic [DEPTH_LOG2-1:0] RD_Addr;
   logic [PRECISION-1:0]  RD_Data;
   logic                  RD_Valid;

   modport master (
      output DAQ_D, DAQ_Trg, CTL_Arm, CTL_Abort, CFG_PRE, RD_Req, RD_Addr,
      input  STS_Busy, STS_Triggered, STS_Done, RD_Data, RD_Valid
   );

   modport slave (
      input  DAQ_D, DAQ_Trg, CTL_Arm, CTL_Abort, CFG_PRE, RD_Req, RD_Addr,
      output STS_Busy, STS_Triggered, STS_Done, RD_Data, RD_Valid
   );
endinterface

// File: rtl/scdaq_capture_dpram.sv
// rtl/scdaq_capture_dpram.sv - simple dual-port record RAM, registered read
module scdaq_capture_dpram #(
   parameter int PRECISION  = 8,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_we,
   input  logic [DEPTH_LOG2-1:0] i_waddr,
   input  logic [PRECISION-1:0]  i_wdata,
   input  logic                  i_re,
   input  logic [DEPTH_LOG2-1:0] i_raddr,
   output logic [PRECISION-1:0]  o_rdata
);
   logic [PRECISION-1:0] r_mem [2**DEPTH_LOG2];
   logic [PRECISION-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // Only the output register is reset; the array keeps its contents.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)  r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/scdaq_capture.sv
// rtl/scdaq_capture.sv - pre/post-trigger record capture into RAM with chronological readback
module scdaq_capture
   import scdaq_capture_pkg::*;
#(
   parameter int PRECISION  = 8,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic           DAQ_Clock,
   input  logic           Reset_n,
   scdaq_capture_if.slave bus
);
   localparam int                  DEPTH    = 2**DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] C_DEPTH  = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] C_ONE    = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] C_WP_1 = DEPTH_LOG2'(1);

   state_t                r_state;
   logic [DEPTH_LOG2-1:0] r_wp;
   logic [DEPTH_LOG2-1:0] r_pre;
   logic [DEPTH_LOG2-1:0] r_start;
   logic [DEPTH_LOG2:0]   r_cnt;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_triggered;
   logic                  r_rd_valid;

   logic [DEPTH_LOG2:0]   w_cnt_inc;
   logic [DEPTH_LOG2:0]   w_post_len;
   logic                  w_rd_en;
   logic [DEPTH_LOG2-1:0] w_rd_addr;
   logic [PRECISION-1:0]  w_rd_data;

   assign w_cnt_inc  = r_cnt + C_ONE;
   assign w_post_len = C_DEPTH - {1'b0, r_pre};
   assign w_rd_en    = bus.RD_Req && (r_state == ST_DONE);
   assign w_rd_addr  = r_start + bus.RD_Addr;

   always_ff @(posedge DAQ_Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state     <= ST_IDLE;
         r_wp        <= '0;
         r_pre       <= '0;
         r_start     <= '0;
         r_cnt       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_triggered <= 1'b0;
         r_rd_valid  <= 1'b0;
      end else begin
         r_rd_valid <= w_rd_en;
         // r_busy mirrors the writing states, so it doubles as the RAM write enable.
         if (r_busy) r_wp <= r_wp + C_WP_1;
         if (bus.CTL_Abort) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_triggered <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE, ST_DONE: begin
                  if (bus.CTL_Arm) begin
                     r_pre       <= bus.CFG_PRE;
                     r_wp        <= '0;
                     r_cnt       <= '0;
                     r_busy      <= 1'b1;
                     r_done      <= 1'b0;
                     r_triggered <= 1'b0;
                     r_state     <= (bus.CFG_PRE == '0) ? ST_WAIT_TRG : ST_PRE;
                  end
               end
               ST_PRE: begin
                  r_cnt <= w_cnt_inc;
                  if (w_cnt_inc == {1'b0, r_pre}) r_state <= ST_WAIT_TRG;
               end
               ST_WAIT_TRG: begin
                  if (bus.DAQ_Trg) begin
                     r_start     <= r_wp - r_pre;
                     r_triggered <= 1'b1;
                     r_cnt       <= C_ONE;
                     if (w_post_len == C_ONE) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end else begin
                        r_state <= ST_POST;
                     end
                  end
               end
               ST_POST: begin
                  r_cnt <= w_cnt_inc;
                  if (w_cnt_inc == w_post_len) begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   scdaq_capture_dpram #(
      .PRECISION  (PRECISION),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_ram (
      .i_clk   (DAQ_Clock),
      .i_rst_n (Reset_n),
      .i_we    (r_busy),
      .i_waddr (r_wp),
      .i_wdata (bus.DAQ_D),
      .i_re    (w_rd_en),
      .i_raddr (w_rd_addr),
      .o_rdata (w_rd_data)
   );

   assign bus.STS_Busy      = r_busy;
   assign bus.STS_Done      = r_done;
   assign bus.STS_Triggered = r_triggered;
   assign bus.RD_Valid      = r_rd_valid;
   assign bus.RD_Data       = w_rd_data;
endmodule

// File: tb/tb_scdaq_capture.sv
// tb/tb_scdaq_capture.sv - scoreboard bench for scdaq_capture
module tb_scdaq_capture;
   localparam int PW    = 8;
   localparam int DL    = 4;
   localparam int DEPTH = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   scdaq_capture_if #(.PRECISION(PW), .DEPTH_LOG2(DL)) bus ();

   scdaq_capture #(.PRECISION(PW), .DEPTH_LOG2(DL)) dut (
      .DAQ_Clock (clk),
      .Reset_n   (rst_n),
      .bus       (bus)
   );

   int            edge_no = 0;
   int            total   = 0;
   int            bad     = 0;
   bit            ramp    = 1'b1;
   logic [PW-1:0] hist [int];
   bit            trg_abs [int];
   logic [PW-1:0] exp_q [$];
   int            offs_q [$];

   always @(posedge clk) edge_no++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no);
      end
   endtask

   // Sample/trigger driver: the value presented for edge e is logged as hist[e].
   initial begin
      logic [PW-1:0] d;
      forever begin
         @(negedge clk);
         d = ramp ? PW'(edge_no + 1) : PW'($urandom);
         bus.DAQ_D   = d;
         hist[edge_no + 1] = d;
         bus.DAQ_Trg = trg_abs.exists(edge_no + 1);
      end
   end

   // Scoreboard monitor.
   initial begin
      logic [PW-1:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.RD_Valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL rd_unexpected: RD_Valid=1 data=%0d, expected no response", bus.RD_Data);
            end else begin
               e = exp_q.pop_front();
               check("rd_data", 32'(bus.RD_Data), 32'(e));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   // Arms with pre-trigger count pre; triggers at arm edge + offs_q[k] (ascending).
   // Accepted trigger is the first one after the pre samples are in.
   task automatic acquire(input int pre, input int glitch_off, output int t);
      int a;
      int acc;
      acc = -1;
      @(negedge clk);
      a = edge_no + 1;
      foreach (offs_q[k]) begin
         trg_abs[a + offs_q[k]] = 1'b1;
         if (acc < 0 && offs_q[k] >= pre + 1) acc = offs_q[k];
      end
      bus.CFG_PRE = DL'(pre);
      bus.CTL_Arm = 1'b1;
      @(negedge clk);
      bus.CTL_Arm = 1'b0;
      check("busy_after_arm", 32'(bus.STS_Busy), 1);
      t = a + acc;
      for (int n = 0; n < 400 && bus.STS_Done !== 1'b1; n++) begin
         bus.CTL_Arm = (glitch_off > 0 && edge_no + 1 == a + glitch_off);
         @(negedge clk);
      end
      bus.CTL_Arm = 1'b0;
      check("done_seen", 32'(bus.STS_Done), 1);
      check("done_edge", 32'(edge_no), 32'(t + DEPTH - pre - 1));
      check("triggered_in_done", 32'(bus.STS_Triggered), 1);
      check("busy_in_done", 32'(bus.STS_Busy), 0);
   endtask

   // Logical index i of the record is the sample taken at edge t - pre + i.
   task automatic read_record(input int t, input int pre, input bit gaps);
      for (int i = 0; i < DEPTH; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            bus.RD_Req = 1'b0;
            @(negedge clk);
         end
         bus.RD_Req  = 1'b1;
         bus.RD_Addr = DL'(i);
         exp_q.push_back(hist[t - pre + i]);
         @(negedge clk);
      end
      bus.RD_Req = 1'b0;
      repeat (2) @(negedge clk);
      check("sb_drained", 32'(exp_q.size()), 0);
   endtask

   initial begin
      int t;
      int a;
      int pre;
      bus.DAQ_D     = '0;
      bus.DAQ_Trg   = 1'b0;
      bus.CTL_Arm   = 1'b0;
      bus.CTL_Abort = 1'b0;
      bus.CFG_PRE   = '0;
      bus.RD_Req    = 1'b0;
      bus.RD_Addr   = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(bus.STS_Busy), 0);
      check("rst_done", 32'(bus.STS_Done), 0);
      check("rst_trig", 32'(bus.STS_Triggered), 0);
      check("rst_rd_valid", 32'(bus.RD_Valid), 0);
      check("rst_rd_data", 32'(bus.RD_Data), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Pre 4, trigger 20 edges after arm.
      offs_q = {20};
      acquire(4, 0, t);
      read_record(t, 4, 1'b0);

      // Asynchronous reset in the middle of POST.
      @(negedge clk);
      a = edge_no + 1;
      trg_abs[a + 5] = 1'b1;
      bus.CFG_PRE = DL'(4);
      bus.CTL_Arm = 1'b1;
      @(negedge clk);
      bus.CTL_Arm = 1'b0;
      repeat (8) @(negedge clk);
      check("trig_before_reset", 32'(bus.STS_Triggered), 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_busy", 32'(bus.STS_Busy), 0);
      check("async_trig", 32'(bus.STS_Triggered), 0);
      check("async_done", 32'(bus.STS_Done), 0);
      check("async_rd_data", 32'(bus.RD_Data), 0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.RD_Req = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("idle_rd_valid", 32'(bus.RD_Valid), 0);
      end
      bus.RD_Req = 1'b0;
      check("idle_busy", 32'(bus.STS_Busy), 0);

      // Zero pre-trigger, trigger on the first writing edge.
      offs_q = {1};
      acquire(0, 0, t);
      read_record(t, 0, 1'b0);

      // Triggers inside PRE are ignored.
      offs_q = {3, 5, 40};
      acquire(8, 0, t);
      read_record(t, 8, 1'b1);

      // Abort with Arm on the third POST edge.
      @(negedge clk);
      a = edge_no + 1;
      trg_abs[a + 3] = 1'b1;
      bus.CFG_PRE = DL'(2);
      bus.CTL_Arm = 1'b1;
      @(negedge clk);
      bus.CTL_Arm = 1'b0;
      repeat (5) @(negedge clk);
      check("post_trig", 32'(bus.STS_Triggered), 1);
      bus.CTL_Abort = 1'b1;
      bus.CTL_Arm   = 1'b1;
      @(negedge clk);
      bus.CTL_Abort = 1'b0;
      bus.CTL_Arm   = 1'b0;
      check("abort_busy", 32'(bus.STS_Busy), 0);
      check("abort_done", 32'(bus.STS_Done), 0);
      check("abort_trig", 32'(bus.STS_Triggered), 0);
      @(negedge clk);
      check("abort_stays_idle", 32'(bus.STS_Busy), 0);

      // Arm pulse in WAIT_TRG is ignored; re-arm in DONE drops Done.
      offs_q = {2, 8};
      acquire(3, 5, t);
      read_record(t, 3, 1'b1);
      bus.CFG_PRE = DL'(3);
      bus.CTL_Arm = 1'b1;
      @(negedge clk);
      bus.CTL_Arm = 1'b0;
      check("rearm_done", 32'(bus.STS_Done), 0);
      check("rearm_busy", 32'(bus.STS_Busy), 1);
      check("rearm_trig", 32'(bus.STS_Triggered), 0);
      bus.CTL_Abort = 1'b1;
      @(negedge clk);
      bus.CTL_Abort = 1'b0;

      // Randomized records, including both pre-trigger extremes.
      ramp = 1'b0;
      for (int k = 0; k < 8; k++) begin
         pre = (k == 0) ? DEPTH - 1 : (k == 1) ? 0 : int'($urandom_range(0, DEPTH - 1));
         offs_q = {};
         if (pre > 0) offs_q.push_back(int'($urandom_range(1, pre)));
         offs_q.push_back(pre + 1 + int'($urandom_range(0, 20)));
         acquire(pre, 0, t);
         read_record(t, pre, 1'b1);
      end

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
